// File: rtl/switch_arb_pkg.sv
// -----------------------------------------------------------------------------
// switch_arb_pkg
//   Shared types and sizing helpers for the N x N crossbar switch arbiter.
//   - arb_state_e : per-output arbitration state (IDLE / OFFER / BUSY)
//   - IDLE_CODE   : request/grant code meaning "no port"
//   - code_width  : width of a request/grant code able to hold 0..n
//   - idx_width   : width of a port index 0..n-1 (at least 1 bit)
//   - timer_width : width of an offer timer counting 0..t-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package switch_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    localparam int unsigned IDLE_CODE = 32'd0;

    function automatic int unsigned code_width(input int unsigned n);
        return (n < 32'd1) ? 32'd1 : $clog2(n + 32'd1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    function automatic int unsigned timer_width(input int unsigned t);
        return (t < 32'd2) ? 32'd1 : $clog2(t);
    endfunction

endpackage

// File: rtl/swarb_rr_pick.sv
// -----------------------------------------------------------------------------
// swarb_rr_pick
//   Combinational round-robin picker. Searches req starting at index ptr and
//   wrapping N-1 -> 0; returns the first set position.
//   Ports:
//     req   in  N    candidate vector
//     ptr   in  IW   search start index (0..N-1)
//     found out 1    at least one candidate set
//     idx   out IW   index of the winning candidate (0 when none)
// -----------------------------------------------------------------------------
module swarb_rr_pick #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Position base+off modulo N; base is always below N so one subtract suffices.
    function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return (s >= int'(N)) ? IW'(s - int'(N)) : IW'(s);
    endfunction

    // Scan from farthest to nearest offset so the nearest candidate is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = {IW{1'b0}};
        for (int k = int'(N) - 1; k >= 0; k--) begin
            found = found | req[rot(ptr, k)];
            idx   = req[rot(ptr, k)] ? rot(ptr, k) : idx;
        end
    end

endmodule

// File: rtl/switch_arbiter_nxn.sv
// -----------------------------------------------------------------------------
// switch_arbiter_nxn
//   N-input x N-output crossbar switch arbiter. Each input carries one request
//   code (0 = idle, 1..N = output port). Each output runs an IDLE/OFFER/BUSY
//   FSM: it picks a requester round-robin, offers the grant, waits for ack with
//   an optional timeout, then holds the connection until the input withdraws.
//
//   Parameters:
//     NUM_PORTS    number of inputs = outputs (2..15)
//     ACK_TIMEOUT  OFFER cycles without ack before withdrawing; 0 = wait forever
//   Ports:
//     clock        in   1             clock
//     reset        in   1             synchronous, active-high reset
//     request      in   NUM_PORTS*PW  request[i*PW +: PW] = code of input i
//     ack          in   NUM_PORTS     ack[o] = output o+1 accepts its offer
//     grant        out  NUM_PORTS*PW  grant[i*PW +: PW] = output granted to input i
//     grant_valid  out  NUM_PORTS     grant code of input i is non-zero
//     out_busy     out  NUM_PORTS     output o+1 is in BUSY
//
//   Build option: SWITCH_ARB_SELF_ROUTE_EN
//     defined   -> input i may be granted output i+1 (loopback testing)
//     undefined -> self-requests are masked and never granted
// -----------------------------------------------------------------------------
module switch_arbiter_nxn
    import switch_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS   = 8,
    parameter  int unsigned ACK_TIMEOUT = 16,
    localparam int unsigned PW          = code_width(NUM_PORTS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_PORTS*PW-1:0] request,
    input  logic [NUM_PORTS-1:0]    ack,
    output logic [NUM_PORTS*PW-1:0] grant,
    output logic [NUM_PORTS-1:0]    grant_valid,
    output logic [NUM_PORTS-1:0]    out_busy
);

    localparam int unsigned IW = idx_width(NUM_PORTS);
    localparam int unsigned TW = timer_width(ACK_TIMEOUT);

    logic [PW-1:0]        req_code [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_mat  [NUM_PORTS];   // req_mat[o][i]: input i competes for output o
    logic                 pick_found [NUM_PORTS];
    logic [IW-1:0]        pick_idx   [NUM_PORTS];

    arb_state_e  state_q [NUM_PORTS];
    arb_state_e  state_d [NUM_PORTS];
    logic [IW-1:0] win_q [NUM_PORTS];
    logic [IW-1:0] win_d [NUM_PORTS];
    logic [IW-1:0] ptr_q [NUM_PORTS];
    logic [IW-1:0] ptr_d [NUM_PORTS];
    logic [TW-1:0] timer_q [NUM_PORTS];
    logic [TW-1:0] timer_d [NUM_PORTS];

    logic [PW-1:0]           gcode_d [NUM_PORTS];
    logic [NUM_PORTS*PW-1:0] grant_d, grant_q;
    logic [NUM_PORTS-1:0]    grant_valid_d, grant_valid_q;
    logic [NUM_PORTS-1:0]    out_busy_d, out_busy_q;

    // Self-route permission for input i towards output o.
    function automatic logic self_ok(input int i, input int o);
`ifdef SWITCH_ARB_SELF_ROUTE_EN
        return (i >= 0) && (o >= 0);
`else
        return i != o;
`endif
    endfunction

    // Successor of a winner index, wrapping N-1 -> 0.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] w);
        return (w == IW'(NUM_PORTS - 32'd1)) ? {IW{1'b0}} : w + IW'(1);
    endfunction

    // Unpack request codes and build the per-output candidate matrix.
    // Codes above NUM_PORTS never equal any o+1, so they behave as idle.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            req_code[i] = request[i*PW +: PW];
        end
        for (int o = 0; o < int'(NUM_PORTS); o++) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                req_mat[o][i] = (req_code[i] == PW'(o + 1)) && self_ok(i, o);
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_pick
        swarb_rr_pick #(
            .N  (NUM_PORTS),
            .IW (IW)
        ) u_pick (
            .req   (req_mat[g]),
            .ptr   (ptr_q[g]),
            .found (pick_found[g]),
            .idx   (pick_idx[g])
        );
    end

    // Per-output FSM next state: ack first, then withdrawal, then timeout.
    always_comb begin
        for (int o = 0; o < int'(NUM_PORTS); o++) begin
            state_d[o] = state_q[o];
            win_d[o]   = win_q[o];
            ptr_d[o]   = ptr_q[o];
            timer_d[o] = timer_q[o];
            case (state_q[o])
                ST_IDLE: begin
                    if (pick_found[o]) begin
                        state_d[o] = ST_OFFER;
                        win_d[o]   = pick_idx[o];
                        timer_d[o] = {TW{1'b0}};
                    end else begin
                        state_d[o] = ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    if (ack[o]) begin
                        state_d[o] = ST_BUSY;
                        ptr_d[o]   = next_idx(win_q[o]);
                        timer_d[o] = {TW{1'b0}};
                    end else if (req_code[win_q[o]] != PW'(o + 1)) begin
                        state_d[o] = ST_IDLE;
                        timer_d[o] = {TW{1'b0}};
                    end else if ((ACK_TIMEOUT != 32'd0) &&
                                 (timer_q[o] == TW'(ACK_TIMEOUT - 32'd1))) begin
                        // Advance past a non-acking winner so others are not starved.
                        state_d[o] = ST_IDLE;
                        ptr_d[o]   = next_idx(win_q[o]);
                        timer_d[o] = {TW{1'b0}};
                    end else begin
                        timer_d[o] = (ACK_TIMEOUT == 32'd0) ? timer_q[o] : timer_q[o] + TW'(1);
                    end
                end
                ST_BUSY: begin
                    if (req_code[win_q[o]] != PW'(o + 1)) begin
                        state_d[o] = ST_IDLE;
                    end else begin
                        state_d[o] = ST_BUSY;
                    end
                end
                default: begin
                    state_d[o] = ST_IDLE;
                    timer_d[o] = {TW{1'b0}};
                end
            endcase
        end
    end

    // Map next-state connections onto per-input grant codes. An input can be
    // held by two outputs only in the ack-with-retarget corner; the lowest
    // output index is shown then.
    always_comb begin
        grant_d       = {(NUM_PORTS*PW){1'b0}};
        grant_valid_d = {NUM_PORTS{1'b0}};
        out_busy_d    = {NUM_PORTS{1'b0}};
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            gcode_d[i] = PW'(IDLE_CODE);
            for (int o = int'(NUM_PORTS) - 1; o >= 0; o--) begin
                gcode_d[i] = ((state_d[o] != ST_IDLE) && (win_d[o] == IW'(i))) ?
                             PW'(o + 1) : gcode_d[i];
            end
            grant_d[i*PW +: PW] = gcode_d[i];
            grant_valid_d[i]    = (gcode_d[i] != PW'(IDLE_CODE));
        end
        for (int o = 0; o < int'(NUM_PORTS); o++) begin
            out_busy_d[o] = (state_d[o] == ST_BUSY);
        end
    end

    // State, pointer, timer and registered-output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int o = 0; o < int'(NUM_PORTS); o++) begin
                state_q[o] <= ST_IDLE;
                win_q[o]   <= {IW{1'b0}};
                ptr_q[o]   <= {IW{1'b0}};
                timer_q[o] <= {TW{1'b0}};
            end
            grant_q       <= {(NUM_PORTS*PW){1'b0}};
            grant_valid_q <= {NUM_PORTS{1'b0}};
            out_busy_q    <= {NUM_PORTS{1'b0}};
        end else begin
            for (int o = 0; o < int'(NUM_PORTS); o++) begin
                state_q[o] <= state_d[o];
                win_q[o]   <= win_d[o];
                ptr_q[o]   <= ptr_d[o];
                timer_q[o] <= timer_d[o];
            end
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            out_busy_q    <= out_busy_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign out_busy    = out_busy_q;

endmodule

// File: tb/tb_switch_arbiter_nxn.sv
// -----------------------------------------------------------------------------
// tb_switch_arbiter_nxn
//   Directed scenarios followed by random traffic, every cycle compared with a
//   behavioural model of the arbitration rules. A second instance with
//   ACK_TIMEOUT=0 shares the stimulus to check the wait-forever setting.
// -----------------------------------------------------------------------------
module tb_switch_arbiter_nxn;

    localparam int N  = 8;
    localparam int T  = 4;
    localparam int PW = 4;

`ifdef SWITCH_ARB_SELF_ROUTE_EN
    localparam bit SELF_EN = 1'b1;
`else
    localparam bit SELF_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic [N*PW-1:0] request;
    logic [N-1:0]  ack;
    logic [N*PW-1:0] grant,   grant_z;
    logic [N-1:0]  grant_valid, grant_valid_z;
    logic [N-1:0]  out_busy,    out_busy_z;

    int total = 0;
    int bad   = 0;

    // Model state: 0 = idle, 1 = offering, 2 = connected
    int m_state [N];
    int m_win   [N];
    int m_ptr   [N];
    int m_tmr   [N];

    switch_arbiter_nxn #(.NUM_PORTS(N), .ACK_TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .request(request), .ack(ack),
        .grant(grant), .grant_valid(grant_valid), .out_busy(out_busy)
    );

    switch_arbiter_nxn #(.NUM_PORTS(N), .ACK_TIMEOUT(0)) dut_nt (
        .clock(clock), .reset(reset), .request(request), .ack(ack),
        .grant(grant_z), .grant_valid(grant_valid_z), .out_busy(out_busy_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int field(input logic [N*PW-1:0] v, input int i);
        return int'(v[i*PW +: PW]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input int c);
        request[i*PW +: PW] = PW'(c);
    endtask

    // Apply one clock edge of the arbitration rules to the model.
    task automatic model_step();
        int ns [N]; int nw [N]; int np [N]; int nt [N];
        int code [N];
        for (int i = 0; i < N; i++) code[i] = int'(request[i*PW +: PW]);
        for (int o = 0; o < N; o++) begin
            ns[o] = m_state[o]; nw[o] = m_win[o]; np[o] = m_ptr[o]; nt[o] = m_tmr[o];
            if (reset) begin
                ns[o] = 0; nw[o] = 0; np[o] = 0; nt[o] = 0;
            end else if (m_state[o] == 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    int c; c = (m_ptr[o] + k) % N;
                    if (code[c] == o + 1 && (SELF_EN || c != o)) begin
                        ns[o] = 1; nw[o] = c; nt[o] = 0;
                    end
                end
            end else if (m_state[o] == 1) begin
                if (ack[o]) begin
                    ns[o] = 2; np[o] = (m_win[o] + 1) % N; nt[o] = 0;
                end else if (code[m_win[o]] != o + 1) begin
                    ns[o] = 0; nt[o] = 0;
                end else if (m_tmr[o] == T - 1) begin
                    ns[o] = 0; np[o] = (m_win[o] + 1) % N; nt[o] = 0;
                end else begin
                    nt[o] = m_tmr[o] + 1;
                end
            end else begin
                if (code[m_win[o]] != o + 1) ns[o] = 0;
            end
        end
        for (int o = 0; o < N; o++) begin
            m_state[o] = ns[o]; m_win[o] = nw[o]; m_ptr[o] = np[o]; m_tmr[o] = nt[o];
        end
    endtask

    task automatic model_compare();
        logic [N*PW-1:0] eg;
        logic [N-1:0] ev, eb;
        eg = '0; ev = '0; eb = '0;
        for (int i = 0; i < N; i++) begin
            int g; g = 0;
            for (int o = N - 1; o >= 0; o--) begin
                if (m_state[o] != 0 && m_win[o] == i) g = o + 1;
            end
            eg[i*PW +: PW] = PW'(g);
            ev[i] = (g != 0);
        end
        for (int o = 0; o < N; o++) eb[o] = (m_state[o] == 2);
        chk("model_grant", 64'(grant), 64'(eg));
        chk("model_grant_valid", 64'(grant_valid), 64'(ev));
        chk("model_out_busy", 64'(out_busy), 64'(eb));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        model_compare();
    endtask

    task automatic do_reset();
        request = '0;
        ack     = '0;
        reset   = 1'b1;
        cycle();
        reset   = 1'b0;
    endtask

    initial begin
        int order [4];
        order = '{0, 2, 5, 0};
        request = '0;
        ack     = '0;
        reset   = 1'b1;
        for (int o = 0; o < N; o++) begin
            m_state[o] = 0; m_win[o] = 0; m_ptr[o] = 0; m_tmr[o] = 0;
        end
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_grant_valid", 64'(grant_valid), 64'd0);
        chk("reset_out_busy", 64'(out_busy), 64'd0);

        // Basic offer, ack, release
        set_req(1, 3);
        cycle();
        chk("t1_grant", 64'(field(grant, 1)), 64'd3);
        chk("t1_valid", 64'(grant_valid[1]), 64'd1);
        ack[2] = 1'b1;
        cycle();
        ack[2] = 1'b0;
        chk("t1_busy", 64'(out_busy[2]), 64'd1);
        set_req(1, 0);
        cycle();
        chk("t1_release_grant", 64'(field(grant, 1)), 64'd0);
        chk("t1_release_busy", 64'(out_busy[2]), 64'd0);

        // Round-robin order among inputs 0, 2, 5 on output 4
        do_reset();
        set_req(0, 4); set_req(2, 4); set_req(5, 4);
        cycle();
        for (int k = 0; k < 4; k++) begin
            chk("t2_rr_winner", 64'(field(grant, order[k])), 64'd4);
            ack[3] = 1'b1;
            cycle();
            ack[3] = 1'b0;
            set_req(order[k], 0);
            cycle();
            set_req(order[k], 4);
            cycle();
        end

        // Timeout withdraws after T offer cycles, then the next requester
        do_reset();
        set_req(3, 1); set_req(6, 1);
        for (int k = 0; k < T; k++) begin
            cycle();
            chk("t3_offer_held", 64'(field(grant, 3)), 64'd1);
        end
        cycle();
        chk("t3_withdrawn", 64'(field(grant, 3)), 64'd0);
        chk("t3_idle_gap", 64'(field(grant, 6)), 64'd0);
        cycle();
        chk("t3_next_offer", 64'(field(grant, 6)), 64'd1);
        chk("t3_no_timeout", 64'(field(grant_z, 3)), 64'd1);

        // Self request and out-of-range code
        do_reset();
        set_req(2, 3);
        cycle();
        cycle();
        chk("t4_self", 64'(field(grant, 2)), SELF_EN ? 64'd3 : 64'd0);
        set_req(2, 0);
        set_req(4, 12);
        cycle();
        cycle();
        chk("t4_range", 64'(field(grant, 4)), 64'd0);

        // Ack coinciding with timeout expiry
        do_reset();
        set_req(1, 5);
        for (int k = 0; k < T; k++) cycle();
        ack[4] = 1'b1;
        cycle();
        ack[4] = 1'b0;
        chk("t5_ack_beats_timeout", 64'(out_busy[4]), 64'd1);
        chk("t5_grant_kept", 64'(field(grant, 1)), 64'd5);
        set_req(1, 0);
        cycle();

        // Ack coinciding with withdrawal
        do_reset();
        set_req(0, 2);
        cycle();
        ack[1] = 1'b1;
        set_req(0, 0);
        cycle();
        ack[1] = 1'b0;
        chk("t5_ack_drop_busy", 64'(out_busy[1]), 64'd1);
        chk("t5_ack_drop_grant", 64'(field(grant, 0)), 64'd2);
        cycle();
        chk("t5_drop_idle", 64'(out_busy[1]), 64'd0);
        chk("t5_drop_grant", 64'(field(grant, 0)), 64'd0);

        // Reset while three outputs are busy, then post-reset contention
        do_reset();
        set_req(0, 2); set_req(1, 3); set_req(2, 4);
        cycle();
        ack = 8'b0000_1110;
        cycle();
        ack = 8'b0000_0000;
        chk("t6_three_busy", 64'(out_busy), 64'h0e);
        set_req(0, 0); set_req(2, 0); set_req(4, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_reset_grant", 64'(grant), 64'd0);
        chk("t6_reset_busy", 64'(out_busy), 64'd0);
        cycle();
        chk("t6_lowest_wins", 64'(field(grant, 1)), 64'd3);
        chk("t6_loser", 64'(field(grant, 4)), 64'd0);

        // Random traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 0);
                    else set_req(i, int'($urandom_range(1, 11)));
                end
            end
            for (int o = 0; o < N; o++) ack[o] = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 249) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
